// File: rtl/i2c_master_pkg.sv
// Shared definitions for the byte-level I2C master: FSM encodings, quarter
// phases, register map and field positions.
package i2c_master_pkg;

    typedef logic [2:0] state_t;
    typedef logic [1:0] phase_t;

    localparam state_t ST_IDLE   = 3'd0;
    localparam state_t ST_START  = 3'd1;
    localparam state_t ST_BIT    = 3'd2;
    localparam state_t ST_ACK    = 3'd3;
    localparam state_t ST_STOP   = 3'd4;
    localparam state_t ST_FINISH = 3'd5;

    localparam phase_t Q0 = 2'd0;
    localparam phase_t Q1 = 2'd1;
    localparam phase_t Q2 = 2'd2;
    localparam phase_t Q3 = 2'd3;

    localparam logic [1:0] REG_CMD      = 2'd0;
    localparam logic [1:0] REG_STATUS   = 2'd1;
    localparam logic [1:0] REG_RXDATA   = 2'd2;
    localparam logic [1:0] REG_PRESCALE = 2'd3;

    localparam int CMD_START = 8;
    localparam int CMD_STOP  = 9;
    localparam int CMD_READ  = 10;
    localparam int CMD_MACK  = 11;

    localparam int STAT_BUSY   = 0;
    localparam int STAT_RXACK  = 1;
    localparam int STAT_DONE   = 2;
    localparam int STAT_ERR    = 3;
    localparam int STAT_IRQ_EN = 4;

    function automatic logic [31:0] pack_status(input logic busy, input logic rxack,
                                                input logic done, input logic err,
                                                input logic irq_en);
        logic [31:0] s;
        s = 32'd0;
        s[STAT_BUSY]   = busy;
        s[STAT_RXACK]  = rxack;
        s[STAT_DONE]   = done;
        s[STAT_ERR]    = err;
        s[STAT_IRQ_EN] = irq_en;
        return s;
    endfunction

endpackage

// File: rtl/i2c_tick_gen.sv
// Quarter-bit tick prescaler: down-counter reloading PRESCALE, frozen while a
// slave stretches SCL, restarted on every accepted command.
module i2c_tick_gen #(
    parameter logic [15:0] DEFAULT_PRESCALE = 16'd124
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [15:0] prescale,
    input  logic        reload,
    input  logic        freeze,
    output logic        tick
);

    logic [15:0] count;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= DEFAULT_PRESCALE;
        end else if (reload) begin
            count <= prescale;
        end else if (!freeze) begin
            count <= (count == 16'd0) ? prescale : count - 16'd1;
        end
    end

    assign tick = (count == 16'd0) && !freeze && !reload;

endmodule

// File: rtl/i2c_byte_master.sv
// Avalon-MM I2C byte master: register file, START/BIT/ACK/STOP sequencer and
// shift register driving open-drain SCL/SDA enables.
module i2c_byte_master
    import i2c_master_pkg::*;
#(
    parameter logic [15:0] DEFAULT_PRESCALE = 16'd124
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [1:0]  address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic        irq,
    input  logic        scl_in,
    input  logic        sda_in,
    output logic        scl_oe,
    output logic        sda_oe
);

    state_t      state;
    phase_t      phase;
    logic [2:0]  bit_cnt;
    logic [7:0]  shreg;
    logic [7:0]  rxdata;
    logic        cmd_stop, cmd_read, cmd_mack;
    logic        rxack, done, err, irq_en;
    logic [15:0] prescale;
    logic        scl_oe_nxt, sda_oe_nxt;
    logic        tick, busy, freeze;
    logic        wr_en, cmd_wr, status_wr, prescale_wr, accept;
    logic        unused_wdata_hi;

    assign unused_wdata_hi = ^writedata[31:16];

    assign busy        = (state != ST_IDLE);
    assign wr_en       = chipselect && !write_n;
    assign cmd_wr      = wr_en && (address == REG_CMD);
    assign status_wr   = wr_en && (address == REG_STATUS);
    assign prescale_wr = wr_en && (address == REG_PRESCALE);
    assign accept      = cmd_wr && !busy;
    // Stretch detection uses the registered enable so the cycle in which we
    // release SCL is not mistaken for a slave holding it low.
    assign freeze      = busy && !scl_oe && !scl_in;

    i2c_tick_gen #(
        .DEFAULT_PRESCALE(DEFAULT_PRESCALE)
    ) u_tick_gen (
        .clk     (clk),
        .reset_n (reset_n),
        .prescale(prescale),
        .reload  (accept),
        .freeze  (freeze),
        .tick    (tick)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= ST_IDLE;
            phase    <= Q0;
            bit_cnt  <= 3'd0;
            rxdata   <= 8'd0;
            rxack    <= 1'b0;
            cmd_stop <= 1'b0;
            cmd_read <= 1'b0;
            cmd_mack <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        state    <= writedata[CMD_START] ? ST_START : ST_BIT;
                        phase    <= Q0;
                        bit_cnt  <= 3'd0;
                        cmd_stop <= writedata[CMD_STOP];
                        cmd_read <= writedata[CMD_READ];
                        cmd_mack <= writedata[CMD_MACK];
                    end
                end
                ST_FINISH: state <= ST_IDLE;
                default: begin
                    if (tick) begin
                        if (state == ST_ACK && phase == Q2 && !cmd_read)
                            rxack <= sda_in;
                        if (phase != Q3) begin
                            phase <= phase_t'(phase + 2'd1);
                        end else begin
                            phase <= Q0;
                            case (state)
                                ST_START: state <= ST_BIT;
                                ST_BIT: begin
                                    if (bit_cnt == 3'd7) state <= ST_ACK;
                                    else bit_cnt <= bit_cnt + 3'd1;
                                end
                                ST_ACK: begin
                                    rxdata <= shreg;
                                    state  <= cmd_stop ? ST_STOP : ST_FINISH;
                                end
                                ST_STOP: state <= ST_FINISH;
                                default: state <= ST_IDLE;
                            endcase
                        end
                    end
                end
            endcase
        end
    end

    // Shift register: MSB drives SDA, bus value shifts in at the end of Q2.
    always_ff @(posedge clk) begin
        if (accept) begin
            shreg <= writedata[7:0];
        end else if (state == ST_BIT && phase == Q2 && tick) begin
            shreg <= {shreg[6:0], sda_in};
        end
    end

    always_comb begin
        scl_oe_nxt = scl_oe;
        sda_oe_nxt = sda_oe;
        case (state)
            ST_START: begin
                case (phase)
                    Q0: begin
                        scl_oe_nxt = 1'b0;
                        sda_oe_nxt = 1'b0;
                    end
                    Q2: sda_oe_nxt = 1'b1;
                    Q3: scl_oe_nxt = 1'b1;
                    default: ;
                endcase
            end
            ST_BIT, ST_ACK: begin
                case (phase)
                    Q0: begin
                        scl_oe_nxt = 1'b1;
                        if (state == ST_BIT) sda_oe_nxt = !cmd_read && !shreg[7];
                        else                 sda_oe_nxt = cmd_read && !cmd_mack;
                    end
                    Q1, Q2: scl_oe_nxt = 1'b0;
                    default: scl_oe_nxt = 1'b1;
                endcase
            end
            ST_STOP: begin
                case (phase)
                    Q0: begin
                        scl_oe_nxt = 1'b1;
                        sda_oe_nxt = 1'b1;
                    end
                    Q1: scl_oe_nxt = 1'b0;
                    Q2: sda_oe_nxt = 1'b0;
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            scl_oe <= 1'b0;
            sda_oe <= 1'b0;
        end else begin
            scl_oe <= scl_oe_nxt;
            sda_oe <= sda_oe_nxt;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            done     <= 1'b0;
            err      <= 1'b0;
            irq_en   <= 1'b0;
            prescale <= DEFAULT_PRESCALE;
        end else begin
            if (state == ST_FINISH)
                done <= 1'b1;
            else if (status_wr && writedata[STAT_DONE])
                done <= 1'b0;
            if (cmd_wr && busy)
                err <= 1'b1;
            else if (status_wr && writedata[STAT_ERR])
                err <= 1'b0;
            if (status_wr)
                irq_en <= writedata[STAT_IRQ_EN];
            if (prescale_wr && !busy)
                prescale <= writedata[15:0];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            readdata <= 32'd0;
        end else begin
            case (address)
                REG_STATUS:   readdata <= pack_status(busy, rxack, done, err, irq_en);
                REG_RXDATA:   readdata <= {24'd0, rxdata};
                REG_PRESCALE: readdata <= {16'd0, prescale};
                default:      readdata <= 32'd0;
            endcase
        end
    end

    assign irq = done && irq_en;

endmodule

// File: tb/tb_i2c_byte_master.sv
// Directed bench for i2c_byte_master with a behavioural I2C slave on the bus
// and a queue of expected results.
module tb_i2c_byte_master;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [1:0]  address = 2'd0;
    logic        chipselect = 1'b0;
    logic        write_n = 1'b1;
    logic [31:0] writedata = 32'd0;
    logic [31:0] readdata;
    logic        irq;
    logic        scl_oe, sda_oe;
    logic        scl_bus, sda_bus;

    logic        slave_scl_low = 1'b0;
    logic        slave_sda_low = 1'b0;
    logic        slave_clear = 1'b0;
    logic        slave_read = 1'b0;
    logic        stretch_en = 1'b0;
    logic [7:0]  rd_byte = 8'd0;
    logic        prev_scl = 1'b1, prev_sda = 1'b1;
    int          rise_cnt = 0;
    int          high_changes = 0, start_cnt = 0, stop_cnt = 0;
    logic        stretch_arm = 1'b0;
    int          stretch_cnt = 0;
    logic        sampled_sda [16];
    logic        sampled_oe  [16];
    int          cyc_cnt = 0;

    int          checks = 0;
    int          errors = 0;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;
    exp_t exp_q[$];

    assign scl_bus = !(scl_oe || slave_scl_low);
    assign sda_bus = !(sda_oe || slave_sda_low);

    i2c_byte_master dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .address   (address),
        .chipselect(chipselect),
        .write_n   (write_n),
        .writedata (writedata),
        .readdata  (readdata),
        .irq       (irq),
        .scl_in    (scl_bus),
        .sda_in    (sda_bus),
        .scl_oe    (scl_oe),
        .sda_oe    (sda_oe)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    // Slave: ACKs writes, serves rd_byte on reads, optionally stretches bit 3.
    always @(posedge clk) begin
        prev_scl <= scl_bus;
        prev_sda <= sda_bus;
        if (slave_clear) begin
            rise_cnt      <= 0;
            high_changes  <= 0;
            start_cnt     <= 0;
            stop_cnt      <= 0;
            stretch_arm   <= stretch_en;
            stretch_cnt   <= 0;
            slave_scl_low <= 1'b0;
            slave_sda_low <= 1'b0;
        end else begin
            if (scl_bus && prev_scl && (sda_bus != prev_sda)) begin
                high_changes <= high_changes + 1;
                if (!sda_bus) begin
                    start_cnt <= start_cnt + 1;
                    rise_cnt  <= 0;
                end else begin
                    stop_cnt <= stop_cnt + 1;
                end
            end
            if (scl_bus && !prev_scl) begin
                if (rise_cnt < 16) begin
                    sampled_sda[rise_cnt] <= sda_bus;
                    sampled_oe[rise_cnt]  <= sda_oe;
                end
                rise_cnt <= rise_cnt + 1;
            end
            if (!scl_bus) begin
                if (slave_read) slave_sda_low <= (rise_cnt < 8) ? !rd_byte[3'(7 - rise_cnt)] : 1'b0;
                else            slave_sda_low <= (rise_cnt == 8);
            end
            if (stretch_arm) begin
                if (!slave_scl_low && rise_cnt == 3 && !scl_bus)
                    slave_scl_low <= 1'b1;
                if (slave_scl_low && !scl_oe) begin
                    stretch_cnt <= stretch_cnt + 1;
                    if (stretch_cnt == 49) begin
                        slave_scl_low <= 1'b0;
                        stretch_arm   <= 1'b0;
                    end
                end
            end
        end
    end

    task automatic push_exp(input string tag, input logic [31:0] val);
        exp_t e;
        e.tag = tag;
        e.val = val;
        exp_q.push_back(e);
    endtask

    task automatic chk(input logic [31:0] obs);
        exp_t e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $error("FAIL scoreboard_empty: observed=%0h expected=none", obs);
        end else begin
            e = exp_q.pop_front();
            assert (obs === e.val) else begin
                errors++;
                $error("FAIL %s: observed=%0h expected=%0h", e.tag, obs, e.val);
            end
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic write_reg(input logic [1:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        cyc();
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic read_reg(input logic [1:0] a, output logic [31:0] d);
        address = a;
        cyc();
        d = readdata;
    endtask

    task automatic arm_slave(input logic rd, input logic [7:0] b, input logic stretch);
        slave_read  = rd;
        rd_byte     = b;
        stretch_en  = stretch;
        slave_clear = 1'b1;
        cyc();
        slave_clear = 1'b0;
    endtask

    // Polls STATUS.DONE through the registered read port; duration counts from
    // the accepting clock edge to the edge where readdata first shows DONE.
    task automatic wait_done(input int t0, input int limit, output int dur);
        address = 2'd1;
        do begin
            cyc();
        end while (readdata[2] !== 1'b1 && (cyc_cnt - t0) < limit);
        dur = cyc_cnt - t0;
    endtask

    function automatic logic [7:0] bus_byte();
        logic [7:0] b;
        for (int i = 0; i < 8; i++) b[7 - i] = sampled_sda[i];
        return b;
    endfunction

    initial begin
        logic [31:0] d;
        int t0, dur;

        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;

        push_exp("rst_scl_oe", 32'd0); chk({31'd0, scl_oe});
        push_exp("rst_sda_oe", 32'd0); chk({31'd0, sda_oe});
        push_exp("rst_irq", 32'd0);    chk({31'd0, irq});
        push_exp("rst_cmd", 32'd0);         read_reg(2'd0, d); chk(d);
        push_exp("rst_status", 32'd0);      read_reg(2'd1, d); chk(d);
        push_exp("rst_rxdata", 32'd0);      read_reg(2'd2, d); chk(d);
        push_exp("rst_prescale", 32'd124);  read_reg(2'd3, d); chk(d);

        write_reg(2'd3, 32'd1);
        push_exp("prescale_set", 32'd1); read_reg(2'd3, d); chk(d);

        // START | STOP write of 0xA5, N = 2: 44*N bus cycles + FINISH + read latency
        arm_slave(1'b0, 8'h00, 1'b0);
        push_exp("wr_busy", 32'd1);
        push_exp("wr_duration", 32'd90);
        push_exp("wr_bus_byte", 32'hA5);
        push_exp("wr_ack_on_bus", 32'd0);
        push_exp("wr_sda_changes_scl_high", 32'd2);
        push_exp("wr_start_cond", 32'd1);
        push_exp("wr_stop_cond", 32'd1);
        push_exp("wr_status", 32'h0000000C);
        push_exp("prescale_busy_ignored", 32'd1);
        push_exp("wr_end_scl_oe", 32'd0);
        push_exp("wr_end_sda_oe", 32'd0);
        push_exp("err_cleared", 32'h00000004);
        write_reg(2'd0, 32'h3A5);
        t0 = cyc_cnt;
        read_reg(2'd1, d); chk(d & 32'd1);
        write_reg(2'd0, 32'h3A5);
        write_reg(2'd3, 32'd9);
        wait_done(t0, 400, dur);
        chk(32'(dur));
        chk({24'd0, bus_byte()});
        chk({31'd0, sampled_sda[8]});
        chk(32'(high_changes));
        chk(32'(start_cnt));
        chk(32'(stop_cnt));
        read_reg(2'd1, d); chk(d);
        read_reg(2'd3, d); chk(d);
        chk({31'd0, scl_oe});
        chk({31'd0, sda_oe});
        write_reg(2'd1, 32'h8);
        read_reg(2'd1, d); chk(d);

        // READ with MACK=1, no START/STOP: 36*N + FINISH + read latency
        write_reg(2'd1, 32'h4);
        arm_slave(1'b1, 8'h3C, 1'b0);
        push_exp("rd_duration", 32'd74);
        push_exp("rd_rxdata", 32'h3C);
        push_exp("rd_9th_pulse_sda", 32'd1);
        push_exp("rd_9th_pulse_sda_oe", 32'd0);
        push_exp("rd_scl_held_low", 32'd1);
        push_exp("rd_status", 32'h4);
        write_reg(2'd0, 32'hC00);
        t0 = cyc_cnt;
        wait_done(t0, 400, dur);
        chk(32'(dur));
        read_reg(2'd2, d); chk(d);
        chk({31'd0, sampled_sda[8]});
        chk({31'd0, sampled_oe[8]});
        chk({31'd0, scl_oe});
        read_reg(2'd1, d); chk(d);

        // Slave stretches SCL for 50 cycles during bit 3
        write_reg(2'd1, 32'h4);
        arm_slave(1'b0, 8'h00, 1'b1);
        push_exp("st_duration", 32'd140);
        push_exp("st_bus_byte", 32'hA5);
        push_exp("st_ack_on_bus", 32'd0);
        push_exp("st_status", 32'h4);
        write_reg(2'd0, 32'h3A5);
        t0 = cyc_cnt;
        wait_done(t0, 600, dur);
        chk(32'(dur));
        chk({24'd0, bus_byte()});
        chk({31'd0, sampled_sda[8]});
        read_reg(2'd1, d); chk(d);

        // Interrupt, then asynchronous reset in the middle of a byte
        write_reg(2'd1, 32'h14);
        push_exp("irq_before", 32'd0); chk({31'd0, irq});
        arm_slave(1'b0, 8'h00, 1'b0);
        push_exp("irq_after_done", 32'd1);
        write_reg(2'd0, 32'h3A5);
        t0 = cyc_cnt;
        wait_done(t0, 400, dur);
        chk({31'd0, irq});
        arm_slave(1'b0, 8'h00, 1'b0);
        push_exp("mid_busy", 32'd1);
        push_exp("arst_scl_oe", 32'd0);
        push_exp("arst_sda_oe", 32'd0);
        push_exp("arst_irq", 32'd0);
        push_exp("arst_readdata", 32'd0);
        push_exp("arst_prescale", 32'd124);
        write_reg(2'd0, 32'h3A5);
        repeat (19) cyc();
        read_reg(2'd1, d); chk(d & 32'd1);
        reset_n = 1'b0;
        #1;
        chk({31'd0, scl_oe});
        chk({31'd0, sda_oe});
        chk({31'd0, irq});
        chk(readdata);
        cyc();
        reset_n = 1'b1;
        read_reg(2'd3, d); chk(d);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/i2c_byte_master.md
# i2c_byte_master

Hardware I2C master that replaces software bit-banging of the board's SCL/SDA lines. The HPS writes byte-level commands over an Avalon-MM slave; the block sequences START, 8 data bits, ACK and STOP on open-drain pads with SCL clock-stretch support. It raises a done interrupt when a command completes. It sits in the Qsys system in place of the two single-bit bidirectional PIOs for SCL and SDA.

## Interface
- DEFAULT_PRESCALE, 124, reset value of PRESCALE; quarter-bit period = PRESCALE+1 clk cycles (124 gives 100 kHz SCL at 50 MHz)
- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- address  in  2  register select
- chipselect  in  1  slave select
- write_n  in  1  active-low write strobe
- writedata  in  32  write data
- readdata  out  32  registered read data, updated every cycle from `address`
- irq  out  1  level interrupt = DONE & IRQ_EN
- scl_in, sda_in  in  1  synchronized pad inputs; the top level adds a 2-flop synchronizer
- scl_oe, sda_oe  out  1  1 = pull line low, 0 = release; top level: pad = oe ? 0 : Z

## Operation
- Register 0, CMD, write only, reads 0. Fields: [7:0] TXBYTE, [8] START, [9] STOP, [10] READ, [11] MACK (master ACK bit driven after a read; 0 = ACK).
- Register 1, STATUS. Fields: [0] BUSY (RO), [1] RXACK (RO, slave ACK sampled; 0 = ACK), [2] DONE (sticky; write 1 to clear), [3] ERR (sticky; write 1 to clear), [4] IRQ_EN (RW).
- Register 2, RXDATA [7:0] RO.
- Register 3, PRESCALE [15:0] RW.
- CMD write while BUSY: command ignored, ERR set. PRESCALE write while BUSY: ignored.
- FSM states: IDLE, START, BIT, ACK, STOP, FINISH. Every non-idle state has 4 quarter phases Q0..Q3, each advancing on a tick.
- Command accept: from IDLE go to START if START=1, else to BIT.
- START: Q0 release SDA and SCL (supports repeated start), Q1 hold, Q2 SDA low, Q3 SCL low.
- BIT, 8 times, MSB first:
  - Q0: SCL low; drive SDA = TXBYTE bit (release if READ=1).
  - Q1: release SCL.
  - Q2: SCL high; sample sda_in into the shift register at the end of Q2.
  - Q3: SCL low.
- ACK: same 4 phases as BIT. On a write, SDA is released and RXACK is sampled. On a read, SDA is driven with MACK. The shift register is copied to RXDATA at the end of ACK.
- After ACK: go to STOP if STOP=1, else FINISH. Without STOP, SCL stays low and SDA stays at its last driven value, so the bus is held.
- STOP: Q0 SCL low, SDA low; Q1 release SCL; Q2 release SDA; Q3 hold.
- FINISH: lasts one cycle; sets DONE, clears BUSY, returns to IDLE.
- Clock stretch: in any phase where SCL is released, the tick counter freezes while scl_in = 0. No timeout. No arbitration detection (single master).

## Timing
- Reset values: scl_oe=0, sda_oe=0, readdata=0, irq=0, STATUS=0, RXDATA=0, PRESCALE=DEFAULT_PRESCALE, FSM in IDLE, tick counter = PRESCALE.
- BUSY reads 1 from the read issued in the cycle after the accepting write (registered readdata adds 1 cycle).
- Tick generator: down-counter reloads PRESCALE on reaching 0 and emits a tick. It reloads on command accept, so the first phase is a full period. PRESCALE=0 gives a tick every cycle.
- Command duration without stretch, with N = PRESCALE+1:
  - START+byte+ACK+STOP: 44·N cycles, plus 1 cycle for FINISH.
  - Byte+ACK only: 36·N cycles, plus 1 cycle.
- Simultaneous STATUS write-1-clear and DONE set: the set wins.
- An async reset mid-transfer releases both lines immediately. This may leave the slave mid-byte; software recovers by issuing a STOP.
- irq is asserted in the cycle after FINISH.

## Structure
- Package `i2c_master_pkg`: FSM state enum, phase type, register offsets (CMD=0, STATUS=1, RXDATA=2, PRESCALE=3), CMD/STATUS bit positions.
- Sub-module `i2c_tick_gen`: prescaler with reload input, freeze input and tick output.
- Top: Avalon register file plus the FSM and shift register.

## Test plan
- Reset, then read all registers: 0, 0, 0, 124; scl_oe=sda_oe=0.
- PRESCALE=1, CMD=0x3A5 (START|STOP, byte 0xA5), slave model ACKs:
  - SDA stable while SCL high, except on the START and STOP edges.
  - Bits on the bus are 1,0,1,0,0,1,0,1.
  - RXACK=0, DONE=1 after 88 cycles plus FINISH.
- CMD=0xC00 (READ, MACK=1, no START/STOP), slave returns 0x3C: RXDATA=0x3C; sda released on the 9th SCL pulse; SCL ends low.
- Slave holds SCL low for 50 cycles during bit 3: phase frozen; total duration +50 cycles; data still correct.
- CMD write while BUSY: command ignored, ERR=1. Write 0x8 to STATUS: ERR cleared. PRESCALE write while BUSY does not change PRESCALE.
- IRQ_EN=1: irq rises after DONE. Assert reset_n mid-byte: scl_oe=sda_oe=0 immediately and irq=0.
